// File: rtl/mem_arbiter_if.sv
// Signal bundle between the mem_arbiter and its requesters/backing memory.
// slave = arbiter view, master = environment (IF stage, MEM stage, memory) view.
interface mem_arbiter_if #(parameter int XLEN = 32);
  logic            i_if_req;
  logic [XLEN-1:0] i_if_addr;
  logic [XLEN-1:0] o_if_rdata;
  logic            o_if_done;

  logic            i_d_req;
  logic            i_d_we;
  logic [XLEN-1:0] i_d_addr;
  logic [XLEN-1:0] i_d_wdata;
  logic [3:0]      i_d_be;
  logic [XLEN-1:0] o_d_rdata;
  logic            o_d_done;

  logic            o_mem_req;
  logic            o_mem_we;
  logic [XLEN-1:0] o_mem_addr;
  logic [XLEN-1:0] o_mem_wdata;
  logic [3:0]      o_mem_be;
  logic            i_mem_ack;
  logic [XLEN-1:0] i_mem_rdata;

  logic [1:0]      o_owner;

  modport slave (
    input  i_if_req, i_if_addr,
    output o_if_rdata, o_if_done,
    input  i_d_req, i_d_we, i_d_addr, i_d_wdata, i_d_be,
    output o_d_rdata, o_d_done,
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be,
    input  i_mem_ack, i_mem_rdata,
    output o_owner
  );

  modport master (
    output i_if_req, i_if_addr,
    input  o_if_rdata, o_if_done,
    output i_d_req, i_d_we, i_d_addr, i_d_wdata, i_d_be,
    input  o_d_rdata, o_d_done,
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be,
    output i_mem_ack, i_mem_rdata,
    input  o_owner
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / data) arbiter serialising transactions onto one memory port.
// ARB_ROUND_ROBIN_EN selects round-robin arbitration; otherwise data has fixed priority.
//
//   state   | meaning
//   IDLE    | no transaction; grant one pending request
//   BUSY_IF | fetch transaction on memory port, waiting for ack
//   BUSY_D  | data transaction on memory port, waiting for ack
//   RESP    | done pulse to the winner; requests not sampled
module mem_arbiter #(
  parameter int XLEN = 32
) (
  input  logic         i_clk,
  input  logic         i_reset,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D, RESP} state_t;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_IF   = 2'b01;
  localparam logic [1:0] OWN_D    = 2'b10;
  localparam logic [XLEN-1:0] WORD_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  state_t          state, state_nxt;
  logic [1:0]      owner, owner_nxt;
  logic            mem_req, mem_req_nxt;
  logic            mem_we, mem_we_nxt;
  logic [XLEN-1:0] mem_addr, mem_addr_nxt;
  logic [XLEN-1:0] mem_wdata, mem_wdata_nxt;
  logic [3:0]      mem_be, mem_be_nxt;
  logic [XLEN-1:0] if_rdata, if_rdata_nxt;
  logic [XLEN-1:0] d_rdata, d_rdata_nxt;
  logic            if_done, if_done_nxt;
  logic            d_done, d_done_nxt;
  logic            pick_d;

`ifdef ARB_ROUND_ROBIN_EN
  // last_d = 1 when data was granted most recently; resets to 1 so fetch wins the first tie
  logic last_d, last_d_nxt;
  assign pick_d = bus.i_d_req && (!bus.i_if_req || !last_d);
`else
  assign pick_d = bus.i_d_req;
`endif

  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    mem_req_nxt   = mem_req;
    mem_we_nxt    = mem_we;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    mem_be_nxt    = mem_be;
    if_rdata_nxt  = if_rdata;
    d_rdata_nxt   = d_rdata;
    if_done_nxt   = 1'b0;
    d_done_nxt    = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    last_d_nxt    = last_d;
`endif
    case (state)
      IDLE: begin
        if (bus.i_d_req || bus.i_if_req) begin
          mem_req_nxt = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
          last_d_nxt  = pick_d;
`endif
          if (pick_d) begin
            state_nxt     = BUSY_D;
            owner_nxt     = OWN_D;
            mem_we_nxt    = bus.i_d_we;
            mem_addr_nxt  = bus.i_d_addr & WORD_MASK;
            mem_wdata_nxt = bus.i_d_wdata;
            mem_be_nxt    = bus.i_d_be;
          end else begin
            state_nxt     = BUSY_IF;
            owner_nxt     = OWN_IF;
            mem_we_nxt    = 1'b0;
            mem_addr_nxt  = bus.i_if_addr & WORD_MASK;
            mem_wdata_nxt = '0;
            mem_be_nxt    = 4'hF;
          end
        end
      end
      BUSY_IF: begin
        if (bus.i_mem_ack) begin
          mem_req_nxt  = 1'b0;
          if_rdata_nxt = bus.i_mem_rdata;
          if_done_nxt  = 1'b1;
          state_nxt    = RESP;
        end
      end
      BUSY_D: begin
        if (bus.i_mem_ack) begin
          mem_req_nxt = 1'b0;
          d_rdata_nxt = bus.i_mem_rdata;
          d_done_nxt  = 1'b1;
          state_nxt   = RESP;
        end
      end
      RESP: begin
        state_nxt = IDLE;
        owner_nxt = OWN_NONE;
      end
      default: begin
        state_nxt   = IDLE;
        owner_nxt   = OWN_NONE;
        mem_req_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state     <= IDLE;
      owner     <= OWN_NONE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= 4'h0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_done   <= 1'b0;
      d_done    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_d    <= 1'b1;
`endif
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      mem_req   <= mem_req_nxt;
      mem_we    <= mem_we_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      mem_be    <= mem_be_nxt;
      if_rdata  <= if_rdata_nxt;
      d_rdata   <= d_rdata_nxt;
      if_done   <= if_done_nxt;
      d_done    <= d_done_nxt;
`ifdef ARB_ROUND_ROBIN_EN
      last_d    <= last_d_nxt;
`endif
    end
  end

  assign bus.o_mem_req   = mem_req;
  assign bus.o_mem_we    = mem_we;
  assign bus.o_mem_addr  = mem_addr;
  assign bus.o_mem_wdata = mem_wdata;
  assign bus.o_mem_be    = mem_be;
  assign bus.o_if_rdata  = if_rdata;
  assign bus.o_if_done   = if_done;
  assign bus.o_d_rdata   = d_rdata;
  assign bus.o_d_done    = d_done;
  assign bus.o_owner     = owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter: one row per clock cycle, plus
// hand-written reset-mid-transaction and post-reset fetch sequences.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.XLEN(32)) bus();

  mem_arbiter #(.XLEN(32)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;

  // Row = inputs driven during a cycle, expected outputs after that cycle's rising edge.
  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req;
    logic        e_we;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic        e_if_done;
    logic        e_d_done;
    logic [31:0] e_rd;
    logic [1:0]  e_owner;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.i_if_req    = 1'b0;
    bus.i_if_addr   = '0;
    bus.i_d_req     = 1'b0;
    bus.i_d_we      = 1'b0;
    bus.i_d_addr    = '0;
    bus.i_d_wdata   = '0;
    bus.i_d_be      = 4'h0;
    bus.i_mem_ack   = 1'b0;
    bus.i_mem_rdata = '0;
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    bus.i_if_req    = v.if_req;
    bus.i_if_addr   = v.if_addr;
    bus.i_d_req     = v.d_req;
    bus.i_d_we      = v.d_we;
    bus.i_d_addr    = v.d_addr;
    bus.i_d_wdata   = v.d_wdata;
    bus.i_d_be      = v.d_be;
    bus.i_mem_ack   = v.ack;
    bus.i_mem_rdata = v.rdata;
    @(posedge clk);
    #1;
    chk($sformatf("row%0d mem_req", idx), {31'b0, bus.o_mem_req}, {31'b0, v.e_req});
    chk($sformatf("row%0d owner", idx), {30'b0, bus.o_owner}, {30'b0, v.e_owner});
    chk($sformatf("row%0d if_done", idx), {31'b0, bus.o_if_done}, {31'b0, v.e_if_done});
    chk($sformatf("row%0d d_done", idx), {31'b0, bus.o_d_done}, {31'b0, v.e_d_done});
    if (v.e_req) begin
      chk($sformatf("row%0d mem_we", idx), {31'b0, bus.o_mem_we}, {31'b0, v.e_we});
      chk($sformatf("row%0d mem_addr", idx), bus.o_mem_addr, v.e_addr);
      chk($sformatf("row%0d mem_be", idx), {28'b0, bus.o_mem_be}, {28'b0, v.e_be});
      if (v.e_we)
        chk($sformatf("row%0d mem_wdata", idx), bus.o_mem_wdata, v.e_wdata);
    end
    if (v.e_if_done)
      chk($sformatf("row%0d if_rdata", idx), bus.o_if_rdata, v.e_rd);
    if (v.e_d_done && !v.d_we)
      chk($sformatf("row%0d d_rdata", idx), bus.o_d_rdata, v.e_rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    int   n;
    logic seen_done;

    // single fetch, unaligned address
    vecs.push_back('{1, 32'h0000_0102, 0, 0, 0, 0, 4'h0, 0, 0,             1, 0, 32'h0000_0100, 4'hF, 0, 0, 0, 0, 2'b01});
    vecs.push_back('{1, 32'h0000_0102, 0, 0, 0, 0, 4'h0, 1, 32'hDEAD_BEEF, 0, 0, 0, 4'h0, 0, 1, 0, 32'hDEAD_BEEF, 2'b01});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 4'h0, 0, 0,                         0, 0, 0, 4'h0, 0, 0, 0, 0, 2'b00});
    // store, ack after four wait cycles
    for (int i = 0; i < 5; i++)
      vecs.push_back('{0, 0, 1, 1, 32'h40, 32'h1234_5678, 4'h3, 0, 0,      1, 1, 32'h40, 4'h3, 32'h1234_5678, 0, 0, 0, 2'b10});
    vecs.push_back('{0, 0, 1, 1, 32'h40, 32'h1234_5678, 4'h3, 1, 32'h0BAD_0BAD, 0, 0, 0, 4'h0, 0, 0, 1, 0, 2'b10});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 4'h0, 0, 0,                         0, 0, 0, 4'h0, 0, 0, 0, 0, 2'b00});
    // stray acks in IDLE
    vecs.push_back('{0, 0, 0, 0, 0, 0, 4'h0, 1, 32'hFFFF_FFFF,             0, 0, 0, 4'h0, 0, 0, 0, 0, 2'b00});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 4'h0, 1, 32'hFFFF_FFFF,             0, 0, 0, 4'h0, 0, 0, 0, 0, 2'b00});
    // load, zero-wait memory
    vecs.push_back('{0, 0, 1, 0, 32'h83, 0, 4'h5, 0, 0,                    1, 0, 32'h80, 4'h5, 0, 0, 0, 0, 2'b10});
    vecs.push_back('{0, 0, 1, 0, 32'h83, 0, 4'h5, 1, 32'hCAFE_F00D,        0, 0, 0, 4'h0, 0, 0, 1, 32'hCAFE_F00D, 2'b10});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 4'h0, 0, 0,                         0, 0, 0, 4'h0, 0, 0, 0, 0, 2'b00});
`ifdef ARB_ROUND_ROBIN_EN
    // ties with both requesters re-raising: IF, D, IF
    vecs.push_back('{1, 32'h200, 1, 0, 32'h300, 0, 4'hF, 0, 0,             1, 0, 32'h200, 4'hF, 0, 0, 0, 0, 2'b01});
    vecs.push_back('{1, 32'h200, 1, 0, 32'h300, 0, 4'hF, 1, 32'h1111_1111, 0, 0, 0, 4'h0, 0, 1, 0, 32'h1111_1111, 2'b01});
    vecs.push_back('{0, 32'h200, 1, 0, 32'h300, 0, 4'hF, 0, 0,             0, 0, 0, 4'h0, 0, 0, 0, 0, 2'b00});
    vecs.push_back('{1, 32'h200, 1, 0, 32'h300, 0, 4'hF, 0, 0,             1, 0, 32'h300, 4'hF, 0, 0, 0, 0, 2'b10});
    vecs.push_back('{1, 32'h200, 1, 0, 32'h300, 0, 4'hF, 1, 32'h2222_2222, 0, 0, 0, 4'h0, 0, 0, 1, 32'h2222_2222, 2'b10});
    vecs.push_back('{1, 32'h200, 0, 0, 32'h300, 0, 4'hF, 0, 0,             0, 0, 0, 4'h0, 0, 0, 0, 0, 2'b00});
    vecs.push_back('{1, 32'h200, 1, 0, 32'h300, 0, 4'hF, 0, 0,             1, 0, 32'h200, 4'hF, 0, 0, 0, 0, 2'b01});
    vecs.push_back('{1, 32'h200, 1, 0, 32'h300, 0, 4'hF, 1, 32'h3333_3333, 0, 0, 0, 4'h0, 0, 1, 0, 32'h3333_3333, 2'b01});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 4'h0, 0, 0,                         0, 0, 0, 4'h0, 0, 0, 0, 0, 2'b00});
`else
    // tie: data first, IF held through RESP and granted in the following IDLE
    vecs.push_back('{1, 32'h200, 1, 0, 32'h300, 0, 4'hF, 0, 0,             1, 0, 32'h300, 4'hF, 0, 0, 0, 0, 2'b10});
    vecs.push_back('{1, 32'h200, 1, 0, 32'h300, 0, 4'hF, 1, 32'h1111_1111, 0, 0, 0, 4'h0, 0, 0, 1, 32'h1111_1111, 2'b10});
    vecs.push_back('{1, 32'h200, 0, 0, 0, 0, 4'h0, 0, 0,                   0, 0, 0, 4'h0, 0, 0, 0, 0, 2'b00});
    vecs.push_back('{1, 32'h200, 0, 0, 0, 0, 4'h0, 0, 0,                   1, 0, 32'h200, 4'hF, 0, 0, 0, 0, 2'b01});
    vecs.push_back('{1, 32'h200, 0, 0, 0, 0, 4'h0, 1, 32'h2222_2222,       0, 0, 0, 4'h0, 0, 1, 0, 32'h2222_2222, 2'b01});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 4'h0, 0, 0,                         0, 0, 0, 4'h0, 0, 0, 0, 0, 2'b00});
`endif

    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset mem_req", {31'b0, bus.o_mem_req}, 32'd0);
    chk("reset mem_be", {28'b0, bus.o_mem_be}, 32'd0);
    chk("reset owner", {30'b0, bus.o_owner}, 32'd0);
    chk("reset if_done", {31'b0, bus.o_if_done}, 32'd0);
    chk("reset d_done", {31'b0, bus.o_d_done}, 32'd0);
    chk("reset mem_addr", bus.o_mem_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i], i);

    // reset asserted mid-cycle while a store is in BUSY_D
    @(negedge clk);
    bus.i_d_req   = 1'b1;
    bus.i_d_we    = 1'b1;
    bus.i_d_addr  = 32'h44;
    bus.i_d_wdata = 32'hAAAA_5555;
    bus.i_d_be    = 4'hC;
    @(posedge clk);
    #1;
    chk("midrst pre mem_req", {31'b0, bus.o_mem_req}, 32'd1);
    chk("midrst pre owner", {30'b0, bus.o_owner}, 32'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst mem_req", {31'b0, bus.o_mem_req}, 32'd0);
    chk("midrst mem_we", {31'b0, bus.o_mem_we}, 32'd0);
    chk("midrst mem_addr", bus.o_mem_addr, 32'd0);
    chk("midrst mem_wdata", bus.o_mem_wdata, 32'd0);
    chk("midrst mem_be", {28'b0, bus.o_mem_be}, 32'd0);
    chk("midrst owner", {30'b0, bus.o_owner}, 32'd0);
    chk("midrst if_rdata", bus.o_if_rdata, 32'd0);
    chk("midrst d_rdata", bus.o_d_rdata, 32'd0);
    @(negedge clk);
    clear_inputs();
    bus.i_mem_ack = 1'b1;
    rst = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (bus.o_d_done || bus.o_if_done || bus.o_mem_req) seen_done = 1'b1;
    end
    chk("midrst no done after reset", {31'b0, seen_done}, 32'd0);

    // fresh fetch serviced normally after the abandoned transaction
    @(negedge clk);
    bus.i_mem_ack = 1'b0;
    bus.i_if_req  = 1'b1;
    bus.i_if_addr = 32'h0000_01FF;
    n = 0;
    while (!bus.o_mem_req && n < 8) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("fresh grant mem_req", {31'b0, bus.o_mem_req}, 32'd1);
    chk("fresh grant latency", n, 32'd1);
    chk("fresh mem_addr", bus.o_mem_addr, 32'h0000_01FC);
    chk("fresh owner", {30'b0, bus.o_owner}, 32'd1);
    @(negedge clk);
    bus.i_mem_ack   = 1'b1;
    bus.i_mem_rdata = 32'h0F0F_1234;
    @(posedge clk);
    #1;
    chk("fresh if_done", {31'b0, bus.o_if_done}, 32'd1);
    chk("fresh if_rdata", bus.o_if_rdata, 32'h0F0F_1234);
    chk("fresh d_done", {31'b0, bus.o_d_done}, 32'd0);
    @(negedge clk);
    clear_inputs();
    @(posedge clk);
    #1;
    chk("fresh done width", {31'b0, bus.o_if_done}, 32'd0);
    chk("fresh idle owner", {30'b0, bus.o_owner}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
